// File: rtl/weight_col_bank_fifo.sv
// rtl/weight_col_bank_fifo.sv - multi-bank weight column buffer for the deconvolution datapath
//
// Serial kernel bytes are written into round-robin banks. Whole WEIGHT_SIZE-element columns
// are read back from the current read bank. A kernel can be replayed with loop-back until a
// flush releases its bank.
//
// Ports:
//   i_clk, i_rst_n          clock (rising edge), asynchronous active-low reset
//   i_wr_en, i_data         element write, column-major order
//   i_rd_en                 request next column (READ state only)
//   i_loop_back             rewind read bank to column 0 (WAIT_END state only)
//   i_flush                 release read bank, advance to next bank
//   o_col_data, o_col_valid column output, one cycle after i_rd_en
//   o_kernel_done           pulses with the last column of a kernel
//   o_loop_fin, o_flush_fin completion pulses for loop-back / flush
//   o_full, o_empty         registered status derived from o_bank_cnt
//   o_bank_cnt              number of complete, unreleased banks
module weight_col_bank_fifo #(
    parameter int BIT_WIDTH   = 8,
    parameter int WEIGHT_SIZE = 5,
    parameter int NUM_BANKS   = 2
) (
    input  logic                               i_clk,
    input  logic                               i_rst_n,
    input  logic                               i_wr_en,
    input  logic [BIT_WIDTH-1:0]               i_data,
    input  logic                               i_rd_en,
    input  logic                               i_loop_back,
    input  logic                               i_flush,
    output logic [BIT_WIDTH*WEIGHT_SIZE-1:0]   o_col_data,
    output logic                               o_col_valid,
    output logic                               o_kernel_done,
    output logic                               o_loop_fin,
    output logic                               o_flush_fin,
    output logic                               o_full,
    output logic                               o_empty,
    output logic [$clog2(NUM_BANKS+1)-1:0]     o_bank_cnt
);

    localparam int ELEMS  = WEIGHT_SIZE * WEIGHT_SIZE;
    localparam int IDX_W  = $clog2(ELEMS);
    localparam int COL_W  = (WEIGHT_SIZE > 1) ? $clog2(WEIGHT_SIZE) : 1;
    localparam int BANK_W = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;
    localparam int CNT_W  = $clog2(NUM_BANKS + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_READ,
        S_WAIT_END
    } state_t;

    state_t state, state_nxt;

    logic [BIT_WIDTH-1:0] mem [NUM_BANKS][ELEMS];

    logic [BANK_W-1:0] wr_bank, rd_bank;
    logic [IDX_W-1:0]  wr_idx;
    logic [COL_W-1:0]  rd_col;
    logic [CNT_W-1:0]  cnt_nxt;

    logic wr_fire, wr_last;
    logic flush_go, rd_go, loop_go, last_col;
    logic [IDX_W-1:0] col_base;
    logic [BIT_WIDTH*WEIGHT_SIZE-1:0] col_word;

    assign wr_fire  = i_wr_en && !o_full;
    assign wr_last  = wr_fire && (wr_idx == IDX_W'(ELEMS - 1));
    assign last_col = (rd_col == COL_W'(WEIGHT_SIZE - 1));

    // Flush has priority over both loop-back and column reads.
    assign flush_go = (state != S_IDLE) && i_flush;
    assign rd_go    = (state == S_READ) && i_rd_en && !i_flush;
    assign loop_go  = (state == S_WAIT_END) && i_loop_back && !i_flush;

    // Completion and release in the same cycle cancel out.
    always_comb begin
        cnt_nxt = o_bank_cnt;
        case ({wr_last, flush_go})
            2'b10:   cnt_nxt = o_bank_cnt + CNT_W'(1);
            2'b01:   cnt_nxt = o_bank_cnt - CNT_W'(1);
            default: cnt_nxt = o_bank_cnt;
        endcase
    end

    always_comb begin
        col_base = IDX_W'(rd_col) * IDX_W'(WEIGHT_SIZE);
        col_word = '0;
        for (int r = 0; r < WEIGHT_SIZE; r++) begin
            col_word[r*BIT_WIDTH +: BIT_WIDTH] = mem[rd_bank][col_base + IDX_W'(r)];
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (o_bank_cnt != '0) state_nxt = S_READ;
            end
            S_READ: begin
                if (flush_go)
                    state_nxt = (cnt_nxt != '0) ? S_READ : S_IDLE;
                else if (rd_go && last_col)
                    state_nxt = S_WAIT_END;
            end
            S_WAIT_END: begin
                if (flush_go)
                    state_nxt = (cnt_nxt != '0) ? S_READ : S_IDLE;
                else if (loop_go)
                    state_nxt = S_READ;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Storage is deliberately not reset.
    always_ff @(posedge i_clk) begin
        if (wr_fire) mem[wr_bank][wr_idx] <= i_data;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state         <= S_IDLE;
            wr_bank       <= '0;
            rd_bank       <= '0;
            wr_idx        <= '0;
            rd_col        <= '0;
            o_bank_cnt    <= '0;
            o_full        <= 1'b0;
            o_empty       <= 1'b1;
            o_col_data    <= '0;
            o_col_valid   <= 1'b0;
            o_kernel_done <= 1'b0;
            o_loop_fin    <= 1'b0;
            o_flush_fin   <= 1'b0;
        end else begin
            state         <= state_nxt;
            o_bank_cnt    <= cnt_nxt;
            o_full        <= (cnt_nxt == CNT_W'(NUM_BANKS));
            o_empty       <= (cnt_nxt == '0);
            o_col_valid   <= rd_go;
            o_kernel_done <= rd_go && last_col;
            o_loop_fin    <= loop_go;
            o_flush_fin   <= flush_go;

            if (wr_fire) begin
                if (wr_last) begin
                    wr_idx  <= '0;
                    wr_bank <= (wr_bank == BANK_W'(NUM_BANKS - 1)) ? '0 : wr_bank + BANK_W'(1);
                end else begin
                    wr_idx <= wr_idx + IDX_W'(1);
                end
            end

            if (flush_go) begin
                rd_col  <= '0;
                rd_bank <= (rd_bank == BANK_W'(NUM_BANKS - 1)) ? '0 : rd_bank + BANK_W'(1);
            end else if (loop_go) begin
                rd_col <= '0;
            end else if (rd_go) begin
                o_col_data <= col_word;
                rd_col     <= last_col ? '0 : rd_col + COL_W'(1);
            end
        end
    end

endmodule
